// File: rtl/sram_like_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the SRAM-like port arbiter.
//   OWNER_INST / OWNER_DATA : owner tags stored in the in-flight FIFO
//   SIZE_BYTE / HALF / WORD : SRAM-like transfer size encodings
//   mem_cmd_t               : one downstream request (everything but req)
// ---------------------------------------------------------------------------
package sram_like_arbiter_pkg;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// ---------------------------------------------------------------------------
// arb_owner_fifo
// In-order FIFO of owner tags, one entry per accepted-but-unanswered request.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, din       : enqueue din (ignored while full)
//   pop, dout       : dequeue head (ignored while empty); dout is the head
//   full, empty     : derived from the registered count only, so a pop in
//                     the same cycle never frees a slot for a push
//   count           : number of entries held
// ---------------------------------------------------------------------------
module arb_owner_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers are exactly log2(DEPTH) bits, so +1 wraps on its own.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage is only meaningful behind count, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
// Shares one SRAM-like memory port between the instruction-fetch requester
// (read-only) and the mem-stage data requester (read/write). Up to
// OUTSTANDING accepted requests may be in flight; responses come back in
// order and are steered to the owner recorded when the address was accepted.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   inst_req/addr                 : fetch request (word reads only)
//   inst_addr_ok/data_ok/rdata    : fetch accept / response
//   data_req/wr/size/addr/wstrb/wdata : load/store request
//   data_addr_ok/data_ok/rdata    : load/store accept / response
//   mem_req/wr/size/addr/wstrb/wdata  : downstream request
//   mem_addr_ok/data_ok/rdata     : downstream accept / in-order response
// ---------------------------------------------------------------------------
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int OWN_W       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(OUTSTANDING) + 1;

   logic             lock_q, lock_d;
   logic [OWN_W-1:0] lock_owner_q, lock_owner_d;
   logic [OWN_W-1:0] grant_owner;
   logic             grant_is_data;
   logic             handshake;
   logic             pop;
   logic             head_is_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [OWN_W-1:0] fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             unused_count;
   mem_cmd_t         inst_cmd;
   mem_cmd_t         data_cmd;
   mem_cmd_t         grant_cmd;

   // A presented-but-unaccepted request pins the grant so the downstream
   // sees a stable request even if the other requester rises meanwhile.
   always_comb begin
      grant_owner = OWN_W'(OWNER_INST);
      if (lock_q) begin
         grant_owner = lock_owner_q;
      end else if (data_req) begin
         grant_owner = OWN_W'(OWNER_DATA);
      end
   end

   assign grant_is_data = (grant_owner == OWN_W'(OWNER_DATA));

   assign inst_cmd  = '{wr: 1'b0, size: SIZE_WORD, addr: inst_addr,
                        wstrb: 4'h0, wdata: 32'h0};
   assign data_cmd  = '{wr: data_wr, size: data_size, addr: data_addr,
                        wstrb: data_wstrb, wdata: data_wdata};
   assign grant_cmd = grant_is_data ? data_cmd : inst_cmd;

   assign mem_req   = (data_req | inst_req) & ~fifo_full & ~reset;
   assign mem_wr    = grant_cmd.wr;
   assign mem_size  = grant_cmd.size;
   assign mem_addr  = grant_cmd.addr;
   assign mem_wstrb = grant_cmd.wstrb;
   assign mem_wdata = grant_cmd.wdata;

   assign handshake    = mem_req & mem_addr_ok;
   assign inst_addr_ok = handshake & ~grant_is_data;
   assign data_addr_ok = handshake & grant_is_data;

   // A response with nothing in flight is a downstream protocol error; it
   // is dropped rather than routed to a stale owner.
   assign pop          = mem_data_ok & ~fifo_empty;
   assign head_is_data = (fifo_dout == OWN_W'(OWNER_DATA));
   assign inst_data_ok = pop & ~head_is_data;
   assign data_data_ok = pop & head_is_data;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_comb begin
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      if (handshake) begin
         lock_d = 1'b0;
      end else if (mem_req) begin
         lock_d       = 1'b1;
         lock_owner_d = grant_owner;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q       <= 1'b0;
         lock_owner_q <= '0;
      end else begin
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   arb_owner_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (OWN_W)
   ) u_owner_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (handshake),
      .pop   (pop),
      .din   (grant_owner),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Occupancy is fully represented by full/empty at this level.
   assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

   localparam int OUTSTANDING = 2;

   logic        clk;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int total;
   int bad;

   sram_like_arbiter #(.OUTSTANDING(OUTSTANDING), .OWN_W(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 3 later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      idle();
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h want=0", mem_req); end
      total++; if (inst_addr_ok !== 1'b0) begin bad++; $display("FAIL rst_inst_addr_ok got=%0h want=0", inst_addr_ok); end
      total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL rst_data_addr_ok got=%0h want=0", data_addr_ok); end
      total++; if (inst_data_ok !== 1'b0) begin bad++; $display("FAIL rst_inst_data_ok got=%0h want=0", inst_data_ok); end
      total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_data_ok got=%0h want=0", data_data_ok); end
      idle();
      step();
      reset = 0;
      step();
   endtask

   task automatic test_inst_read();
      inst_req = 1; inst_addr = 32'h1C00_0100; mem_addr_ok = 1;
      #3;
      total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL ir_addr_ok got=%0h want=1", inst_addr_ok); end
      total++; if ({mem_wr, mem_size, mem_addr} !== {1'b0, 2'd2, 32'h1C00_0100})
         begin bad++; $display("FAIL ir_fields got=%0h want=%0h", {mem_wr, mem_size, mem_addr}, {1'b0, 2'd2, 32'h1C00_0100}); end
      step();
      inst_req = 0; mem_addr_ok = 0;
      for (int c = 1; c < 3; c++) begin
         #3;
         total++; if (inst_data_ok !== 1'b0) begin bad++; $display("FAIL ir_early_ok cyc=%0d got=%0h want=0", c, inst_data_ok); end
         step();
      end
      mem_data_ok = 1; mem_rdata = 32'h1234_5678;
      #3;
      total++; if (inst_data_ok !== 1'b1) begin bad++; $display("FAIL ir_data_ok got=%0h want=1", inst_data_ok); end
      total++; if (inst_rdata !== 32'h1234_5678) begin bad++; $display("FAIL ir_rdata got=%0h want=12345678", inst_rdata); end
      total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL ir_data_data_ok got=%0h want=0", data_data_ok); end
      step();
      idle();
      step();
   endtask

   task automatic test_priority();
      inst_req = 1; inst_addr = 32'h1C00_0200;
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h1C00_0004;
      data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
      #3;
      total++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL pr_first_ok got=%0b want=10", {data_addr_ok, inst_addr_ok}); end
      total++; if ({mem_wr, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h1C00_0004, 4'hF, 32'hDEAD_BEEF})
         begin bad++; $display("FAIL pr_store_fields got=%0h want=%0h", {mem_wr, mem_addr, mem_wstrb, mem_wdata}, {1'b1, 32'h1C00_0004, 4'hF, 32'hDEAD_BEEF}); end
      step();
      data_req = 0;
      #3;
      total++; if ({data_addr_ok, inst_addr_ok} !== 2'b01) begin bad++; $display("FAIL pr_second_ok got=%0b want=01", {data_addr_ok, inst_addr_ok}); end
      total++; if ({mem_wr, mem_addr, mem_wstrb, mem_wdata} !== {1'b0, 32'h1C00_0200, 4'h0, 32'h0})
         begin bad++; $display("FAIL pr_inst_fields got=%0h want=%0h", {mem_wr, mem_addr, mem_wstrb, mem_wdata}, {1'b0, 32'h1C00_0200, 4'h0, 32'h0}); end
      step();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_00A1;
      #3;
      total++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin bad++; $display("FAIL pr_resp1 got=%0b want=10", {data_data_ok, inst_data_ok}); end
      step();
      mem_rdata = 32'hCAFE_0002;
      #3;
      total++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin bad++; $display("FAIL pr_resp2 got=%0b want=01", {data_data_ok, inst_data_ok}); end
      total++; if (inst_rdata !== 32'hCAFE_0002) begin bad++; $display("FAIL pr_rdata got=%0h want=cafe0002", inst_rdata); end
      step();
      idle();
      step();
   endtask

   task automatic test_lock();
      inst_req = 1; inst_addr = 32'h1C00_0300; mem_addr_ok = 0;
      #3;
      total++; if (mem_addr !== 32'h1C00_0300 || inst_addr_ok !== 1'b0)
         begin bad++; $display("FAIL lk_c0 got=%0h/%0h want=1c000300/0", mem_addr, inst_addr_ok); end
      step();
      data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h1C00_0402;
      #3;
      total++; if ({mem_wr, mem_addr} !== {1'b0, 32'h1C00_0300} || data_addr_ok !== 1'b0)
         begin bad++; $display("FAIL lk_c1 got=%0h/%0h want=1c000300/0", mem_addr, data_addr_ok); end
      step();
      mem_addr_ok = 1;
      #3;
      total++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0300)
         begin bad++; $display("FAIL lk_c2 got=%0h/%0h want=1/1c000300", inst_addr_ok, mem_addr); end
      step();
      inst_req = 0;
      #3;
      total++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0402 || mem_size !== 2'd1)
         begin bad++; $display("FAIL lk_c3 got=%0h/%0h/%0h want=1/1c000402/1", data_addr_ok, mem_addr, mem_size); end
      step();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      #3;
      total++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin bad++; $display("FAIL lk_resp1 got=%0b want=01", {data_data_ok, inst_data_ok}); end
      step();
      #3;
      total++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin bad++; $display("FAIL lk_resp2 got=%0b want=10", {data_data_ok, inst_data_ok}); end
      step();
      idle();
      step();
   endtask

   task automatic test_full();
      inst_req = 1; inst_addr = 32'h1C00_1000; mem_addr_ok = 1;
      #3;
      total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL fu_acc0 got=%0h want=1", inst_addr_ok); end
      step();
      inst_addr = 32'h1C00_1004;
      #3;
      total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL fu_acc1 got=%0h want=1", inst_addr_ok); end
      step();
      inst_addr = 32'h1C00_1008; mem_data_ok = 1;
      #3;
      total++; if ({mem_req, inst_addr_ok} !== 2'b00) begin bad++; $display("FAIL fu_blocked got=%0b want=00", {mem_req, inst_addr_ok}); end
      total++; if (inst_data_ok !== 1'b1) begin bad++; $display("FAIL fu_pop_while_full got=%0h want=1", inst_data_ok); end
      step();
      mem_data_ok = 0;
      #3;
      total++; if ({mem_req, inst_addr_ok} !== 2'b11 || mem_addr !== 32'h1C00_1008)
         begin bad++; $display("FAIL fu_third got=%0b/%0h want=11/1c001008", {mem_req, inst_addr_ok}, mem_addr); end
      step();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      for (int i = 0; i < 2; i++) begin
         #3;
         total++; if (inst_data_ok !== 1'b1) begin bad++; $display("FAIL fu_drain%0d got=%0h want=1", i, inst_data_ok); end
         step();
      end
      idle();
      #3;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fu_idle_req got=%0h want=0", mem_req); end
      step();
   endtask

   task automatic test_spurious();
      mem_data_ok = 1; mem_rdata = 32'h5555_AAAA;
      #3;
      total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL sp_ok got=%0b want=00", {inst_data_ok, data_data_ok}); end
      step();
      // Count must still be exactly 0: two more accepts fill, a third blocks.
      mem_data_ok = 0; data_req = 1; data_addr = 32'h1C00_2000; mem_addr_ok = 1;
      for (int i = 0; i < 2; i++) begin
         #3;
         total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL sp_acc%0d got=%0h want=1", i, data_addr_ok); end
         step();
      end
      #3;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sp_full got=%0h want=0", mem_req); end
      step();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      for (int i = 0; i < 2; i++) begin
         #3;
         total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL sp_drain%0d got=%0h want=1", i, data_data_ok); end
         step();
      end
      idle();
      step();
   endtask

   task automatic test_async_reset();
      inst_req = 1; inst_addr = 32'h1C00_3000; mem_addr_ok = 1;
      step();
      inst_req = 0; data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h1C00_3004; data_wstrb = 4'h3;
      step();
      data_req = 0; inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      #2;
      reset = 1;
      #1;
      total++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
         begin bad++; $display("FAIL ar_outputs got=%05b want=00000", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
      idle();
      #1;
      reset = 0;
      step();
      inst_req = 1; inst_addr = 32'h1C00_3100; mem_addr_ok = 1;
      #3;
      total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL ar_acc got=%0h want=1", inst_addr_ok); end
      step();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
      #3;
      total++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h0BAD_F00D)
         begin bad++; $display("FAIL ar_resp got=%0b/%0h want=10/0badf00d", {inst_data_ok, data_data_ok}, inst_rdata); end
      step();
      #3;
      total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL ar_stale got=%0b want=00", {inst_data_ok, data_data_ok}); end
      step();
      idle();
      step();
   endtask

   // Reference: a queue of owners in acceptance order, plus the owner whose
   // request was presented last cycle without being accepted (it keeps the port).
   task automatic test_random();
      int          owners[$];
      int          stuck;
      int          g;
      bit          ip, dp, exp_full, exp_req, exp_hs, exp_pop, exp_ido, exp_ddo;
      logic [70:0] exp_fields;
      stuck = -1; ip = 0; dp = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom; data_wdata = $urandom;
            data_wstrb = data_wr ? 4'($urandom) : 4'h0;
         end
         inst_req = ip; data_req = dp;
         mem_addr_ok = 1'($urandom_range(0, 1));
         mem_data_ok = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
         #3;
         exp_full = owners.size() >= OUTSTANDING;
         g = (stuck >= 0) ? stuck : (dp ? 1 : 0);
         exp_req = (ip || dp) && !exp_full;
         exp_hs = exp_req && mem_addr_ok;
         exp_pop = mem_data_ok && owners.size() > 0;
         exp_ido = exp_pop && owners[0] == 0;
         exp_ddo = exp_pop && owners[0] == 1;
         total++; if (mem_req !== exp_req) begin bad++; $display("FAIL rnd_mem_req cyc=%0d got=%0h want=%0h", cyc, mem_req, exp_req); end
         total++; if ({inst_addr_ok, data_addr_ok} !== {exp_hs && g == 0, exp_hs && g == 1})
            begin bad++; $display("FAIL rnd_addr_ok cyc=%0d got=%0b want=%0b", cyc, {inst_addr_ok, data_addr_ok}, {exp_hs && g == 0, exp_hs && g == 1}); end
         total++; if ({inst_data_ok, data_data_ok} !== {exp_ido, exp_ddo})
            begin bad++; $display("FAIL rnd_data_ok cyc=%0d got=%0b want=%0b", cyc, {inst_data_ok, data_data_ok}, {exp_ido, exp_ddo}); end
         if (exp_req) begin
            exp_fields = (g == 1) ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                                  : {1'b0, 2'd2, inst_addr, 4'h0, 32'h0};
            total++; if ({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} !== exp_fields)
               begin bad++; $display("FAIL rnd_fields cyc=%0d got=%0h want=%0h", cyc, {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, exp_fields); end
         end
         if (exp_pop) begin
            total++; if ((exp_ido ? inst_rdata : data_rdata) !== mem_rdata)
               begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%0h want=%0h", cyc, exp_ido ? inst_rdata : data_rdata, mem_rdata); end
         end
         if (exp_pop) void'(owners.pop_front());
         if (exp_hs) begin
            owners.push_back(g);
            stuck = -1;
            if (g == 1) dp = 0; else ip = 0;
         end else if (exp_req) begin
            stuck = g;
         end
         step();
      end
      idle();
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1;
      idle();
      test_reset();
      test_inst_read();
      test_priority();
      test_lock();
      test_full();
      test_spurious();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
